// File: rtl/cpx_seq_ctrl.sv
// Instruction sequencer for the complex add/mul datapath: fetch, two operand reads,
// ALU start/done handshake with timeout, and write-back of the result to data memory.
module cpx_seq_ctrl #(
  parameter int AW      = 5,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   instr_count,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc,
  input  logic          im_op,
  input  logic [AW-1:0] im_dst,
  input  logic [AW-1:0] im_src1,
  input  logic [AW-1:0] im_src0,
  output logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_rdata,
  output logic          dm_we,
  output logic [DW-1:0] dm_wdata,
  output logic          alu_start,
  output logic          alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic          alu_done,
  input  logic [DW-1:0] alu_result
);

  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_RD0, S_RD1, S_EXEC, S_WAIT, S_WB, S_DONE
  } state_t;

  state_t          state;
  logic [AW:0]     cnt;
  logic [AW-1:0]   dst;
  logic [AW-1:0]   src1;
  logic [TCW-1:0]  tcnt;

  // Strobes, busy and dm_addr are registered on the transition into the state
  // that owns them, so every control output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      alu_start <= 1'b0;
      alu_op    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      cnt       <= '0;
      dst       <= '0;
      src1      <= '0;
      tcnt      <= '0;
    end else begin
      done      <= 1'b0;
      dm_we     <= 1'b0;
      alu_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt  <= instr_count;
            pc   <= '0;
            err  <= 1'b0;
            busy <= 1'b1;
            if (instr_count == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          alu_op  <= im_op;
          dst     <= im_dst;
          src1    <= im_src1;
          dm_addr <= im_src0;
          state   <= S_RD0;
        end
        S_RD0: begin
          alu_a   <= dm_rdata;
          dm_addr <= src1;
          state   <= S_RD1;
        end
        S_RD1: begin
          alu_b     <= dm_rdata;
          alu_start <= 1'b1;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // a done arriving on the last allowed cycle still wins over the abort
          if (alu_done) begin
            dm_wdata <= alu_result;
            dm_addr  <= dst;
            dm_we    <= 1'b1;
            state    <= S_WB;
          end else if (tcnt == TCW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WB: begin
          if ({1'b0, pc} == cnt - 1'b1) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpx_seq_ctrl.sv
// Bench for cpx_seq_ctrl: memory/imem/ALU responders plus a sequential program model
// that predicts every ALU request, every write, run latency and the final memory image.
module tb_cpx_seq_ctrl;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int TIMEOUT = 64;
  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   instr_count = '0;
  logic          busy, done, err, dm_we, alu_start, alu_op;
  logic [AW-1:0] pc, dm_addr, im_dst, im_src1, im_src0;
  logic          im_op;
  logic [DW-1:0] dm_rdata, dm_wdata, alu_a, alu_b;
  logic          alu_done = 1'b0;
  logic [DW-1:0] alu_result = '0;

  logic [DW-1:0] mem [N];
  logic          imo [N];
  logic [AW-1:0] imd [N];
  logic [AW-1:0] ims1 [N];
  logic [AW-1:0] ims0 [N];

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic op; logic [DW-1:0] a; logic [DW-1:0] b; } rq_t;
  wr_t wq[$];
  rq_t rq[$];

  int tests = 0, fails = 0, cyc = 0, done_cnt = 0;
  int alu_lat = 1, cd = 0;
  bit spur = 1'b0;
  logic [DW-1:0] pend = '0;

  cpx_seq_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .instr_count(instr_count),
    .busy(busy), .done(done), .err(err), .pc(pc),
    .im_op(im_op), .im_dst(im_dst), .im_src1(im_src1), .im_src0(im_src0),
    .dm_addr(dm_addr), .dm_rdata(dm_rdata), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign im_op    = imo[pc];
  assign im_dst   = imd[pc];
  assign im_src1  = ims1[pc];
  assign im_src0  = ims0[pc];
  assign dm_rdata = mem[dm_addr];

  // Complex arithmetic on {re, im} signed bytes, results wrap to 8 bits each.
  function automatic logic [15:0] cpx(input logic op, input logic [15:0] a, input logic [15:0] b);
    int ar, ai, br, bi, re, im;
    ar = int'($signed(a[15:8])); ai = int'($signed(a[7:0]));
    br = int'($signed(b[15:8])); bi = int'($signed(b[7:0]));
    if (op) begin re = ar * br - ai * bi; im = ar * bi + ai * br; end
    else    begin re = ar + br;           im = ai + bi;           end
    return {re[7:0], im[7:0]};
  endfunction

  // ALU responder: alu_lat cycles after the request; 0 means it never answers.
  always @(posedge clk) begin
    alu_done   <= spur;
    alu_result <= 16'hDEAD;
    if (rst) begin
      alu_done <= 1'b0;
      cd       <= 0;
    end else if (alu_start && alu_lat == 1) begin
      alu_done   <= 1'b1;
      alu_result <= cpx(alu_op, alu_a, alu_b);
    end else if (alu_start && alu_lat > 1) begin
      alu_done <= 1'b0;
      cd       <= alu_lat - 1;
      pend     <= cpx(alu_op, alu_a, alu_b);
    end else if (cd == 1) begin
      cd         <= 0;
      alu_done   <= 1'b1;
      alu_result <= pend;
    end else if (cd > 1) begin
      cd       <= cd - 1;
      alu_done <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cmp_cycle();
    wr_t w;
    rq_t q;
    if (alu_start) begin
      if (rq.size() == 0) begin
        tests++; fails++;
        $display("FAIL alu_req: got alu_start=1 expected 0");
      end else begin
        q = rq.pop_front();
        chk("alu_op", 32'(alu_op), 32'(q.op));
        chk("alu_a", 32'(alu_a), 32'(q.a));
        chk("alu_b", 32'(alu_b), 32'(q.b));
      end
    end
    if (dm_we) begin
      if (wq.size() == 0) begin
        tests++; fails++;
        $display("FAIL dm_write: got dm_we=1 addr %0h expected no write", dm_addr);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", 32'(dm_addr), 32'(w.addr));
        chk("wr_data", 32'(dm_wdata), 32'(w.data));
      end
    end
    if (done) done_cnt++;
  endtask

  task automatic set_i(input int i, input logic op, input int dst, input int s1, input int s0);
    imo[i] = op; imd[i] = 5'(dst); ims1[i] = 5'(s1); ims0[i] = 5'(s0);
  endtask

  task automatic load_prog();
    for (int i = 0; i < N; i++) begin mem[i] = '0; set_i(i, 1'b0, 0, 0, 0); end
    mem[0] = 16'h0102; mem[1] = 16'h0304; mem[2] = 16'h0001; mem[3] = 16'h0100;
    set_i(0, 1'b1, 4, 1, 0);
    set_i(1, 1'b0, 5, 0, 0);
    set_i(2, 1'b1, 6, 2, 1);
    set_i(3, 1'b0, 7, 3, 2);
  endtask

  task automatic recover();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    wq.delete(); rq.delete();
  endtask

  // Run n instructions; the model executes them in order against a copy of memory.
  task automatic run_prog(input int n, input int lat, input bit abort, input bit poke);
    logic [DW-1:0] mm [N];
    logic [DW-1:0] r;
    wr_t w;
    rq_t q;
    int t0, exp_k, dc0, bad;
    bit seen;
    mm = mem;
    wq.delete(); rq.delete();
    for (int i = 0; i < n; i++) begin
      q.op = imo[i]; q.a = mm[ims0[i]]; q.b = mm[ims1[i]];
      rq.push_back(q);
      if (abort) break;
      r = cpx(q.op, q.a, q.b);
      mm[imd[i]] = r;
      w.addr = imd[i]; w.data = r;
      wq.push_back(w);
    end
    exp_k   = abort ? 4 + TIMEOUT : n * (5 + lat);
    alu_lat = abort ? 0 : lat;
    dc0     = done_cnt;
    @(negedge clk);
    start = 1'b1; instr_count = 6'(n);
    @(posedge clk); #1;
    start = 1'b0; t0 = cyc;
    chk("busy_after_start", 32'(busy), 32'(1));
    chk("err_cleared", 32'(err), 32'(0));
    seen = 1'b0;
    for (int j = 0; j < exp_k + 40; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin seen = 1'b1; break; end
      if (poke && (j == 7 || j == 20)) begin start = 1'b1; instr_count = 6'd1; end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL done_wait: got no done within %0d cycles expected %0d", exp_k + 40, exp_k);
      recover();
      return;
    end
    chk("latency", 32'(cyc - t0), 32'(exp_k));
    chk("err_at_done", 32'(err), 32'(abort));
    chk("pc_at_done", 32'(pc), 32'((abort || n == 0) ? 0 : n - 1));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'(0));
    chk("busy_idle", 32'(busy), 32'(0));
    chk("err_hold", 32'(err), 32'(abort));
    chk("done_count", 32'(done_cnt - dc0), 32'(1));
    chk("writes_left", 32'(wq.size()), 32'(0));
    chk("reqs_left", 32'(rq.size()), 32'(0));
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== mm[i]) bad++;
    chk("mem_final", 32'(bad), 32'(0));
  endtask

  task automatic check_prog_literals();
    chk("prog_mem4", 32'(mem[4]), 32'h0000FB0A);
    chk("prog_mem5", 32'(mem[5]), 32'h00000204);
    chk("prog_mem6", 32'(mem[6]), 32'h0000FC03);
    chk("prog_mem7", 32'(mem[7]), 32'h00000101);
  endtask

  task automatic randomize_all();
    for (int i = 0; i < N; i++) begin
      mem[i] = 16'($urandom);
      set_i(i, 1'($urandom), int'($urandom_range(0, N - 1)),
            int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)));
    end
  endtask

  initial begin
    int ns, dc0;
    bit hit;
    fork
      forever begin @(negedge clk); if (!rst) cmp_cycle(); end
      forever begin @(posedge clk); if (dm_we) mem[dm_addr] = dm_wdata; end
    join_none

    load_prog();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_pc", 32'(pc), 32'(0));
    chk("rst_dm_we", 32'(dm_we), 32'(0));
    chk("rst_alu_start", 32'(alu_start), 32'(0));
    chk("rst_regs", 32'({alu_op, alu_a, alu_b, dm_wdata} != '0), 32'(0));
    rst = 1'b0;

    run_prog(4, 1, 1'b0, 1'b0);
    check_prog_literals();

    load_prog();
    set_i(0, 1'b0, 8, 0, 0);
    set_i(1, 1'b0, 9, 8, 8);
    run_prog(2, 1, 1'b0, 1'b0);
    chk("dep_mem8", 32'(mem[8]), 32'h00000204);
    chk("dep_mem9", 32'(mem[9]), 32'h00000408);

    run_prog(0, 1, 1'b0, 1'b0);

    randomize_all();
    run_prog(3, 1, 1'b1, 1'b0);
    run_prog(2, 3, 1'b0, 1'b0);

    // Abandon the run while instruction 2 waits on the ALU.
    load_prog();
    mem[6] = 16'h1111; mem[7] = 16'h2222;
    run_prog(2, 1, 1'b0, 1'b0);
    mem[4] = 16'h0; mem[5] = 16'h0;
    wq.delete(); rq.delete();
    begin
      rq_t q;
      wr_t w;
      logic [DW-1:0] mm [N];
      mm = mem;
      for (int i = 0; i < 3; i++) begin
        q.op = imo[i]; q.a = mm[ims0[i]]; q.b = mm[ims1[i]];
        rq.push_back(q);
        if (i < 2) begin
          w.addr = imd[i]; w.data = cpx(q.op, q.a, q.b);
          mm[imd[i]] = w.data;
          wq.push_back(w);
        end
      end
    end
    alu_lat = 1;
    dc0 = done_cnt;
    @(negedge clk); start = 1'b1; instr_count = 6'd4;
    @(negedge clk); start = 1'b0;
    ns = 0; hit = 1'b0;
    for (int j = 0; j < 100; j++) begin
      if (alu_start) ns++;
      if (ns == 3) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    if (!hit) begin
      tests++; fails++;
      $display("FAIL rst_mid_wait: got %0d alu_start pulses expected 3", ns);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_pc", 32'(pc), 32'(0));
    chk("midrst_dm_we", 32'(dm_we), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_mem6", 32'(mem[6]), 32'h00001111);
    chk("midrst_mem7", 32'(mem[7]), 32'h00002222);
    chk("midrst_no_done", 32'(done_cnt - dc0), 32'(0));
    chk("midrst_writes", 32'(wq.size()), 32'(0));
    chk("midrst_reqs", 32'(rq.size()), 32'(0));

    load_prog();
    spur = 1'b1;
    run_prog(4, 1, 1'b0, 1'b1);
    spur = 1'b0;
    check_prog_literals();

    for (int r = 0; r < 6; r++) begin
      randomize_all();
      run_prog(int'($urandom_range(1, N)), int'($urandom_range(1, 4)), 1'b0, 1'b0);
    end
    randomize_all();
    run_prog(N, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
